tone_synth: RTL and testbench
=============================

# tone_synth

Phase-accumulator tone generator: the output-side counterpart of the YIN pitch detector. It accepts a fixed-point frequency word in the detector's output format and produces an offset-binary audio sample stream at the system sample rate. Its output is suitable for the DAC path or for looping back into the detector as a closed-loop test source. A sequential restoring divider converts each new frequency into a phase increment while tone generation continues uninterrupted.

## Interface
- SIG_WIDTH, 9: output sample width, offset binary
- WIDTH, 32: frequency word width, unsigned Hz with FRAC_BITS fractional bits
- FRAC_BITS, 5: fractional bits of f_in
- SAMPLE_RATE, 8000: sample rate in Hz
- PHASE_WIDTH, 24: phase accumulator width
- F_MIN, 100: lowest synthesised frequency in Hz
- F_MAX, 1000: highest synthesised frequency in Hz; must be at most SAMPLE_RATE/2
- clk_in  input  1  system clock; the only clock
- rst_in  input  1  reset, asynchronous, active-low
- f_in  input  WIDTH  requested frequency, [WIDTH-1:FRAC_BITS] integer and [FRAC_BITS-1:0] fraction
- f_in_valid  input  1  f_in is presented
- f_in_ready  output  1  block can accept f_in
- sample_tick  input  1  one-cycle strobe at SAMPLE_RATE
- sig_out  output  SIG_WIDTH  audio sample
- sig_out_valid  output  1  one-cycle pulse, sig_out is new

## Operation
- Reset (rst_in low, async) sets:
  - sig_out = 2^(SIG_WIDTH-1), which is midscale (MID).
  - sig_out_valid = 0 and f_in_ready = 1.
  - phase = 0, inc = 0, muted = 1, state = IDLE.
- Control FSM has two states, IDLE and DIV.
  - IDLE: f_in_ready = 1. Handshake is f_in_valid && f_in_ready.
    - f_in < F_MIN·2^FRAC_BITS (including 0): muted = 1 and phase = 0 on the next edge. No DIV; the block stays in IDLE.
    - Otherwise: f_eff = min(f_in, F_MAX·2^FRAC_BITS). Load numerator = f_eff << PHASE_WIDTH and go to DIV.
  - DIV: f_in_ready = 0, so f_in_valid is ignored.
    - Restoring division by the constant SAMPLE_RATE·2^FRAC_BITS, one numerator bit per cycle, for WIDTH+PHASE_WIDTH cycles.
    - On the last iteration: inc = quotient[PHASE_WIDTH-1:0] and muted = 0, then return to IDLE.
  - inc = floor(f_eff·2^PHASE_WIDTH / (SAMPLE_RATE·2^FRAC_BITS)). The F_MAX clamp guarantees inc ≤ 2^(PHASE_WIDTH-1), so there is no overflow.
- Generator runs independently of the FSM. On each sample_tick:
  - sig_out = wave(phase), or MID if muted.
  - phase = phase + inc, modulo 2^PHASE_WIDTH; phase is held when muted.
  - sig_out_valid = 1 on the following cycle only.
- Frequency changes are phase-continuous. Unmuting starts from phase 0.
- wave(): q = phase[PW-1:PW-2] and r = phase[PW-3:PW-SIG_WIDTH-1], which is SIG_WIDTH-1 bits. Triangle, with MAX = 2^SIG_WIDTH-1:
  - q=0: MID+r
  - q=1: MAX−r
  - q=2: MID−1−r
  - q=3: r

## Timing
- Handshake accepted at edge N:
  - f_in_ready is low from cycle N+1 through N+WIDTH+PHASE_WIDTH, which is 56 cycles at defaults.
  - The new inc is visible at edge N+WIDTH+PHASE_WIDTH.
  - f_in_ready is high again in the following cycle.
- A mute request accepted at edge N takes effect at N+1. A tick at N+1 outputs MID.
- sample_tick at edge T: sig_out and sig_out_valid update at T+1. Latency is 1 cycle.
- A tick in the same cycle as the handshake, or during DIV, uses the old inc. A tick in the same cycle as the inc load also uses the old inc.
- Back-to-back ticks on consecutive cycles are supported, and each produces its own valid pulse.
- Reset mid-DIV aborts the division and returns to the reset values immediately.

## Configuration
- SINE_LUT_EN defined:
  - wave() uses a quarter-wave ROM L of 2^(SIG_WIDTH-1) entries, with L[k] = round((MID−1)·sin(π/2·k/2^(SIG_WIDTH-1))).
  - Output by quadrant: q0 gives MID+L[r], q1 gives MID+L[~r], q2 gives MID−1−L[r], q3 gives MID−1−L[~r].
- SINE_LUT_EN undefined: triangle per Operation, with no ROM inferred. All other behaviour is identical.

## Test plan
- Reset, then 4 ticks with no f_in → four sig_out_valid pulses, sig_out=256 each; f_in_ready=1.
- f_in=32000 (1000 Hz) → f_in_ready low 56 cycles; inc=2097152. With triangle, successive ticks give 256,384,511,383,255,127,0,128, repeating with period 8.
- f_in=14080 (440 Hz) → inc=922746; after 8000 ticks, phase=(8000·922746) mod 2^24.
- f_in=64000 (2000 Hz, above F_MAX) → clamped; identical sequence to the 1000 Hz case. Then f_in=0 → next tick gives 256, and the output holds at 256.
- Ticks every 3 cycles during DIV after a 440→1000 Hz change → the old inc is used until the load edge, with no phase discontinuity. f_in_valid pulses during DIV are ignored.
- rst_in asserted low at cycle 20 of DIV → outputs are at reset values asynchronously; after release, f_in_ready=1 and ticks output 256.

Source files
------------

// File: rtl/tone_synth_if.sv
// tone_synth_if: frequency request handshake, sample strobe and audio output bundle.
// master drives frequency requests and the sample strobe; slave is the synthesiser.
interface tone_synth_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIG_WIDTH = 9
);

  logic [WIDTH-1:0]     f_in;
  logic                 f_in_valid;
  logic                 f_in_ready;
  logic                 sample_tick;
  logic [SIG_WIDTH-1:0] sig_out;
  logic                 sig_out_valid;

  modport master (
    output f_in,
    output f_in_valid,
    output sample_tick,
    input  f_in_ready,
    input  sig_out,
    input  sig_out_valid
  );

  modport slave (
    input  f_in,
    input  f_in_valid,
    input  sample_tick,
    output f_in_ready,
    output sig_out,
    output sig_out_valid
  );

endinterface

// File: rtl/tone_synth.sv
// tone_synth: phase-accumulator tone generator driven by fixed-point frequency words.
// A sequential restoring divider turns each accepted frequency into a phase increment
// while the generator keeps producing samples with the previous increment.
// Optional feature macro: SINE_LUT_EN selects a quarter-wave sine ROM instead of the
// default triangle waveform.
module tone_synth #(
  parameter int unsigned SIG_WIDTH   = 9,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FRAC_BITS   = 5,
  parameter int unsigned SAMPLE_RATE = 8000,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned F_MIN       = 100,
  parameter int unsigned F_MAX       = 1000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  tone_synth_if.slave bus
);

  // Divider geometry: numerator is f_eff << PHASE_WIDTH, divisor is the fixed-point sample rate.
  localparam int unsigned NUM_W   = WIDTH + PHASE_WIDTH;
  localparam int unsigned DIVISOR = SAMPLE_RATE * (2 ** FRAC_BITS);
  localparam int unsigned REM_W   = $clog2(DIVISOR);
  localparam int unsigned TRIAL_W = REM_W + 1;
  localparam int unsigned CNT_W   = $clog2(NUM_W);

  localparam logic [WIDTH-1:0]   FMIN_FX  = WIDTH'(F_MIN * (2 ** FRAC_BITS));
  localparam logic [WIDTH-1:0]   FMAX_FX  = WIDTH'(F_MAX * (2 ** FRAC_BITS));
  localparam logic [TRIAL_W-1:0] DIV_C    = TRIAL_W'(DIVISOR);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(NUM_W - 1);

  localparam int unsigned MID = 2 ** (SIG_WIDTH - 1);
  localparam int unsigned MAX = (2 ** SIG_WIDTH) - 1;
  localparam logic [SIG_WIDTH-1:0] MID_C = SIG_WIDTH'(MID);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DIV  = 1'b1;

  // Control FSM state
  logic [0:0]             state_q, state_d;
  logic [NUM_W-1:0]       num_q, num_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic                   muted_q, muted_d;
  logic                   ready_q, ready_d;

  // Control FSM combinational helpers
  logic                   mute_req_c;
  logic [TRIAL_W-1:0]     trial_c;
  logic                   q_bit_c;
  logic [WIDTH-1:0]       f_eff_c;

  // Generator state
  logic [PHASE_WIDTH-1:0] phase_q;
  logic [SIG_WIDTH-1:0]   sig_q;
  logic                   sig_valid_q;
  logic [SIG_WIDTH-1:0]   wave_c;
  logic [1:0]             quad_c;
  logic [SIG_WIDTH-2:0]   res_c;

  assign bus.f_in_ready    = ready_q;
  assign bus.sig_out       = sig_q;
  assign bus.sig_out_valid = sig_valid_q;

  // Control FSM and divider registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      inc_q   <= '0;
      muted_q <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      muted_q <= muted_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: accept frequency requests in IDLE, one restoring-division step per DIV cycle
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    inc_d      = inc_q;
    muted_d    = muted_q;
    ready_d    = ready_q;
    mute_req_c = 1'b0;
    trial_c    = {rem_q, num_q[NUM_W-1]};
    q_bit_c    = (trial_c >= DIV_C);
    f_eff_c    = (bus.f_in > FMAX_FX) ? FMAX_FX : bus.f_in;

    case (state_q)
      IDLE: begin
        if (bus.f_in_valid && ready_q) begin
          if (bus.f_in < FMIN_FX) begin
            // Below the audible floor: silence the output and rewind the phase.
            muted_d    = 1'b1;
            mute_req_c = 1'b1;
          end else begin
            num_d   = {f_eff_c, PHASE_WIDTH'(0)};
            rem_d   = '0;
            cnt_d   = '0;
            ready_d = 1'b0;
            state_d = DIV;
          end
        end
      end

      DIV: begin
        // Quotient bits shift into the bottom of num as numerator bits leave the top.
        rem_d = q_bit_c ? REM_W'(trial_c - DIV_C) : trial_c[REM_W-1:0];
        num_d = {num_q[NUM_W-2:0], q_bit_c};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          inc_d   = num_d[PHASE_WIDTH-1:0];
          muted_d = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Phase fields: quadrant select and in-quadrant ramp position
  always_comb begin
    quad_c = phase_q[PHASE_WIDTH-1:PHASE_WIDTH-2];
    res_c  = phase_q[PHASE_WIDTH-3:PHASE_WIDTH-SIG_WIDTH-1];
  end

`ifdef SINE_LUT_EN
  localparam int unsigned LUT_N = 2 ** (SIG_WIDTH - 1);

  // Quarter-wave sine amplitude, rounded to the nearest code
  function automatic logic [SIG_WIDTH-2:0] lut_entry(input int unsigned k);
    real ang;
    ang = $sin(3.141592653589793 / 2.0 * real'(k) / real'(LUT_N));
    return (SIG_WIDTH - 1)'($rtoi(real'(MID - 1) * ang + 0.5));
  endfunction

  logic [SIG_WIDTH-2:0] lut_c [LUT_N];
  logic [SIG_WIDTH-2:0] res_n_c;

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut_c[k] = lut_entry(k);
  end

  // Sine waveform mirrored across quadrants from the quarter-wave table
  always_comb begin
    res_n_c = ~res_c;
    wave_c  = MID_C;
    case (quad_c)
      2'd0:    wave_c = MID_C + SIG_WIDTH'(lut_c[res_c]);
      2'd1:    wave_c = MID_C + SIG_WIDTH'(lut_c[res_n_c]);
      2'd2:    wave_c = SIG_WIDTH'(MID - 1) - SIG_WIDTH'(lut_c[res_c]);
      default: wave_c = SIG_WIDTH'(MID - 1) - SIG_WIDTH'(lut_c[res_n_c]);
    endcase
  end
`else
  // Triangle waveform: rise from MID to MAX, fall through MID to 0, rise back
  always_comb begin
    wave_c = MID_C;
    case (quad_c)
      2'd0:    wave_c = MID_C + SIG_WIDTH'(res_c);
      2'd1:    wave_c = SIG_WIDTH'(MAX) - SIG_WIDTH'(res_c);
      2'd2:    wave_c = SIG_WIDTH'(MID - 1) - SIG_WIDTH'(res_c);
      default: wave_c = SIG_WIDTH'(res_c);
    endcase
  end
`endif

  // Generator: emit a sample and advance the phase on every sample tick
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_q     <= '0;
      sig_q       <= MID_C;
      sig_valid_q <= 1'b0;
    end else begin
      sig_valid_q <= bus.sample_tick;
      if (bus.sample_tick) begin
        sig_q <= muted_q ? MID_C : wave_c;
      end
      if (mute_req_c) begin
        phase_q <= '0;
      end else if (bus.sample_tick && !muted_q) begin
        phase_q <= phase_q + inc_q;
      end
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: scoreboard bench for tone_synth; stimulus pushes expected samples,
// a negedge monitor pops and compares whenever sig_out_valid is seen.
module tb_tone_synth;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 9;
  localparam int unsigned PW = 24;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  tone_synth_if #(.WIDTH(W), .SIG_WIDTH(SW)) bus ();

  tone_synth u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] exp_q[$];
  logic [PW-1:0] m_phase;
  logic [PW-1:0] m_inc;
  bit            m_muted;
  logic [SW-1:0] seq1k [8];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference triangle shape from the phase word
  function automatic logic [SW-1:0] tri_wave(input logic [PW-1:0] p);
    int r;
    r = int'(p[21:14]);
    case (p[23:22])
      2'd0:    return SW'(256 + r);
      2'd1:    return SW'(511 - r);
      2'd2:    return SW'(255 - r);
      default: return SW'(r);
    endcase
  endfunction

  // Push the expected sample for a tick and advance the model phase
  task automatic sb_push(input logic [PW-1:0] inc_used, input int hand);
    logic [SW-1:0] e;
    e = m_muted ? SW'(256) : tri_wave(m_phase);
    if (hand >= 0) e = SW'(hand);
    exp_q.push_back(e);
    if (!m_muted) m_phase = m_phase + inc_used;
  endtask

  task automatic tick(input int hand);
    sb_push(m_inc, hand);
    bus.sample_tick = 1'b1;
    @(negedge clk_in);
    bus.sample_tick = 1'b0;
  endtask

  // Issue a frequency request; measure the busy window when a division is expected
  task automatic send_freq(input logic [W-1:0] f, input logic [PW-1:0] inc_exp, input string nm);
    int guard;
    int lows;
    guard = 0;
    while (!bus.f_in_ready && guard < 500) begin
      @(negedge clk_in);
      guard++;
    end
    check({nm, "_ready_wait"}, longint'(bus.f_in_ready), 1);
    bus.f_in       = f;
    bus.f_in_valid = 1'b1;
    @(negedge clk_in);
    bus.f_in_valid = 1'b0;
    if (f >= W'(3200)) begin
      lows = 0;
      while (!bus.f_in_ready && lows < 500) begin
        lows++;
        @(negedge clk_in);
      end
      check({nm, "_busy_cycles"}, lows, 56);
      m_inc   = inc_exp;
      m_muted = 1'b0;
    end else begin
      check({nm, "_ready_stays"}, longint'(bus.f_in_ready), 1);
      m_muted = 1'b1;
      m_phase = '0;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && bus.sig_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_valid: got sig_out=%0d expected no pulse", bus.sig_out);
      end else begin
        check("sig_out", longint'(bus.sig_out), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0] old_inc;
    logic [PW-1:0] new_inc;
    int lows;

    seq1k = '{9'd256, 9'd384, 9'd511, 9'd383, 9'd255, 9'd127, 9'd0, 9'd128};
    m_phase = '0;
    m_inc   = '0;
    m_muted = 1'b1;
    bus.f_in        = '0;
    bus.f_in_valid  = 1'b0;
    bus.sample_tick = 1'b0;
    rst_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_ready", longint'(bus.f_in_ready), 1);
    check("rst_sig_out", longint'(bus.sig_out), 256);
    check("rst_valid", longint'(bus.sig_out_valid), 0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Muted after reset: spaced ticks give midscale
    for (int i = 0; i < 4; i++) begin
      tick(256);
      @(negedge clk_in);
    end
    check("idle_ready", longint'(bus.f_in_ready), 1);

    // 1000 Hz: inc = 2^21, period-8 triangle
    send_freq(W'(32000), PW'(2097152), "f1000");
    for (int i = 0; i < 16; i++) tick(int'(seq1k[i % 8]));

    // 440 Hz: 8000 ticks, then the next sample reflects phase 16770176
    send_freq(W'(14080), PW'(922746), "f440");
    for (int i = 0; i < 8000; i++) tick(-1);
    tick(255);

    // 440 -> 1000 Hz with ticks every 3 cycles through the division
    old_inc = PW'(922746);
    new_inc = PW'(2097152);
    bus.f_in        = W'(32000);
    bus.f_in_valid  = 1'b1;
    bus.sample_tick = 1'b1;
    sb_push(old_inc, -1);
    @(negedge clk_in);
    bus.f_in_valid  = 1'b0;
    bus.sample_tick = 1'b0;
    bus.f_in        = '0;
    lows = 0;
    for (int c = 1; c <= 70; c++) begin
      if (!bus.f_in_ready) lows++;
      bus.sample_tick = ((c % 3) == 0);
      if ((c % 3) == 0) sb_push((c <= 56) ? old_inc : new_inc, -1);
      bus.f_in_valid = ((c % 10) == 5) && (c <= 50);
      @(negedge clk_in);
    end
    bus.sample_tick = 1'b0;
    bus.f_in_valid  = 1'b0;
    check("change_busy_cycles", lows, 56);
    m_inc   = new_inc;
    m_muted = 1'b0;
    tick(-1);
    tick(-1);

    // Clamp: 2000 Hz behaves as 1000 Hz after a mute rewinds the phase
    send_freq(W'(0), PW'(0), "mute0");
    send_freq(W'(64000), PW'(2097152), "f2000");
    for (int i = 0; i < 16; i++) tick(int'(seq1k[i % 8]));
    send_freq(W'(0), PW'(0), "mute1");
    for (int i = 0; i < 3; i++) tick(256);

    // Reset in the middle of a division
    send_freq(W'(32000), PW'(2097152), "f1000b");
    tick(256);
    tick(384);
    repeat (2) @(negedge clk_in);
    bus.f_in       = W'(14080);
    bus.f_in_valid = 1'b1;
    @(negedge clk_in);
    bus.f_in_valid = 1'b0;
    repeat (19) @(negedge clk_in);
    check("div_busy_before_rst", longint'(bus.f_in_ready), 0);
    #2 rst_in = 1'b0;
    #1;
    check("midrst_ready", longint'(bus.f_in_ready), 1);
    check("midrst_sig_out", longint'(bus.sig_out), 256);
    check("midrst_valid", longint'(bus.sig_out_valid), 0);
    repeat (2) @(negedge clk_in);
    rst_in  = 1'b1;
    m_phase = '0;
    m_inc   = '0;
    m_muted = 1'b1;
    @(negedge clk_in);
    check("postrst_ready", longint'(bus.f_in_ready), 1);
    for (int i = 0; i < 3; i++) tick(256);

    repeat (4) @(negedge clk_in);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
